// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : adc_seq_pkg
// Brief  : Shared types and CSR encodings for the ADC sequencer controller.
// Rev    : 1.0  initial release
// ============================================================================
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_START = 3'd1,
        ST_RUN      = 3'd2,
        ST_WR_STOP  = 3'd3,
        ST_POLL_RD  = 3'd4,
        ST_POLL_CHK = 3'd5
    } seq_state_t;

    localparam logic       CSR_CMD_ADDR = 1'b0;
    localparam logic [2:0] MODE_CONT    = 3'd0;
    localparam logic [2:0] MODE_SINGLE  = 3'd1;
    localparam int         RUN_BIT      = 0;
    localparam int         DATA_W       = 12;
    localparam int         CH_W         = 5;

    function automatic logic [31:0] csr_cmd(input logic [2:0] mode, input logic run);
        return {28'b0, mode, run};
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sample_bank.sv
`default_nettype none
// ============================================================================
// Module : adc_sample_bank
// Brief  : Per-channel sample storage with registered read port.
//          Build option ADC_AVG_EN turns each entry into an IIR accumulator.
// Rev    : 1.0  initial release
// ============================================================================
module adc_sample_bank
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH    = 18,
    parameter int AVG_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [CH_W-1:0]   i_rd_ch,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [NUM_CH-1:0] o_sample_valid
);

`ifdef ADC_AVG_EN
    localparam int ACC_W = DATA_W + AVG_SHIFT;
`else
    localparam int ACC_W = DATA_W;
`endif

    logic [ACC_W-1:0]  r_acc [NUM_CH];
    logic [NUM_CH-1:0] r_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_wr_hit;
    logic              w_rd_hit;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic [DATA_W-1:0] w_rd_val;

    assign w_wr_hit = i_wr_en && (int'(i_wr_ch) < NUM_CH);
    assign w_rd_hit = (int'(i_rd_ch) < NUM_CH);

`ifdef ADC_AVG_EN
    // First capture seeds the accumulator at full weight so the average starts at the sample.
    always_comb begin
        w_acc_nxt = '0;
        if (w_wr_hit) begin
            if (!r_valid[i_wr_ch]) begin
                w_acc_nxt = ACC_W'(i_wr_data) << AVG_SHIFT;
            end else begin
                w_acc_nxt = r_acc[i_wr_ch] - (r_acc[i_wr_ch] >> AVG_SHIFT) + ACC_W'(i_wr_data);
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        if (w_rd_hit) begin
            w_rd_val = DATA_W'(r_acc[i_rd_ch] >> AVG_SHIFT);
        end
    end
`else
    logic w_unused_shift;
    assign w_unused_shift = (AVG_SHIFT != 0);

    always_comb begin
        w_acc_nxt = i_wr_data;
    end

    always_comb begin
        w_rd_val = '0;
        if (w_rd_hit) begin
            w_rd_val = r_acc[i_rd_ch];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
            end
            r_valid   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_hit) begin
                r_acc[i_wr_ch]   <= w_acc_nxt;
                r_valid[i_wr_ch] <= 1'b1;
            end
            r_rd_data <= w_rd_val;
        end
    end

    assign o_rd_data      = r_rd_data;
    assign o_sample_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/adc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : adc_seq_ctrl
// Brief  : Host-side ADC sequencer controller: CSR start/stop, response capture,
//          completion and error flags. Build option: ADC_AVG_EN (bank averaging).
// Rev    : 1.0  initial release
// ============================================================================
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH        = 18,
    parameter int TIMEOUT_CYC   = 4096,
    parameter int STOP_POLL_MAX = 256,
    parameter int AVG_SHIFT     = 3
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    input  logic              stop,
    input  logic              single,
    output logic              csr_address,
    output logic              csr_read,
    output logic              csr_write,
    output logic [31:0]       csr_writedata,
    input  logic [31:0]       csr_readdata,
    input  logic              rsp_valid,
    input  logic [CH_W-1:0]   rsp_channel,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_sop,
    input  logic              rsp_eop,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0] sample_valid,
    output logic              seq_done,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_ch,
    input  logic              err_clr
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int PC_W = $clog2(STOP_POLL_MAX + 1);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic            r_single;
    logic [TO_W-1:0] r_to_cnt;
    logic [PC_W-1:0] r_poll_cnt;
    logic            r_err_to;
    logic            r_err_ch;
    logic            r_seq_done;

    logic            w_timeout;
    logic            w_poll_exhaust;
    logic            w_bad_ch;
    logic            w_unused_bits;

    assign w_unused_bits  = ^{csr_readdata[31:1], rsp_sop};

    // A beat in the final counted cycle still proves the core is alive.
    assign w_timeout      = (r_state == ST_RUN) && !rsp_valid
                            && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_poll_exhaust = (r_state == ST_POLL_CHK) && csr_readdata[RUN_BIT]
                            && (r_poll_cnt == PC_W'(STOP_POLL_MAX));
    assign w_bad_ch       = rsp_valid && (int'(rsp_channel) >= NUM_CH);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        csr_write     = 1'b0;
        csr_read      = 1'b0;
        csr_writedata = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_WR_START;
                end
            end
            ST_WR_START: begin
                csr_write     = 1'b1;
                csr_writedata = csr_cmd(r_single ? MODE_SINGLE : MODE_CONT, 1'b1);
                w_state_nxt   = ST_RUN;
            end
            ST_RUN: begin
                if (stop || w_timeout) begin
                    w_state_nxt = ST_WR_STOP;
                end else if (r_single && rsp_valid && rsp_eop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_STOP: begin
                csr_write     = 1'b1;
                csr_writedata = csr_cmd(MODE_CONT, 1'b0);
                w_state_nxt   = ST_POLL_RD;
            end
            ST_POLL_RD: begin
                csr_read    = 1'b1;
                w_state_nxt = ST_POLL_CHK;
            end
            ST_POLL_CHK: begin
                if (!csr_readdata[RUN_BIT] || w_poll_exhaust) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_POLL_RD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_single   <= 1'b0;
            r_to_cnt   <= '0;
            r_poll_cnt <= '0;
            r_err_to   <= 1'b0;
            r_err_ch   <= 1'b0;
            r_seq_done <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_single <= single;
            end

            if ((r_state != ST_RUN) || rsp_valid) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (r_state == ST_WR_STOP) begin
                r_poll_cnt <= '0;
            end else if (r_state == ST_POLL_RD) begin
                r_poll_cnt <= r_poll_cnt + PC_W'(1);
            end

            // A new error in the same cycle as err_clr must not be lost.
            if (w_timeout || w_poll_exhaust) begin
                r_err_to <= 1'b1;
            end else if (err_clr) begin
                r_err_to <= 1'b0;
            end

            if (w_bad_ch) begin
                r_err_ch <= 1'b1;
            end else if (err_clr) begin
                r_err_ch <= 1'b0;
            end

            r_seq_done <= rsp_valid && rsp_eop;
        end
    end

    assign csr_address = CSR_CMD_ADDR;
    assign busy        = (r_state != ST_IDLE);
    assign err_timeout = r_err_to;
    assign err_ch      = r_err_ch;
    assign seq_done    = r_seq_done;

    adc_sample_bank #(
        .NUM_CH    (NUM_CH),
        .AVG_SHIFT (AVG_SHIFT)
    ) u_bank (
        .clk            (clk_clk),
        .rst            (reset_reset),
        .i_wr_en        (rsp_valid),
        .i_wr_ch        (rsp_channel),
        .i_wr_data      (rsp_data),
        .i_rd_ch        (rd_ch),
        .o_rd_data      (rd_data),
        .o_sample_valid (sample_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_adc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_adc_seq_ctrl
// Brief  : Self-checking bench for adc_seq_ctrl with a behavioural bank model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_adc_seq_ctrl;

    localparam int NUM_CH = 18;
    localparam int TO     = 16;
    localparam int SPM    = 4;
    localparam int SH     = 1;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        start, stop, single;
    logic        csr_address, csr_read, csr_write;
    logic [31:0] csr_writedata, csr_readdata;
    logic        rsp_valid, rsp_sop, rsp_eop;
    logic [4:0]  rsp_channel, rd_ch;
    logic [11:0] rsp_data, rd_data;
    logic [NUM_CH-1:0] sample_valid;
    logic        seq_done, busy, err_timeout, err_ch, err_clr;

    int checks = 0;
    int errors = 0;

    int m_acc [NUM_CH];
    bit m_valid [NUM_CH];
    bit m_err_ch;

    adc_seq_ctrl #(
        .NUM_CH(NUM_CH), .TIMEOUT_CYC(TO), .STOP_POLL_MAX(SPM), .AVG_SHIFT(SH)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start), .stop(stop),
        .single(single), .csr_address(csr_address), .csr_read(csr_read),
        .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
        .rsp_sop(rsp_sop), .rsp_eop(rsp_eop), .rd_ch(rd_ch), .rd_data(rd_data),
        .sample_valid(sample_valid), .seq_done(seq_done), .busy(busy),
        .err_timeout(err_timeout), .err_ch(err_ch), .err_clr(err_clr)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i]   = 0;
            m_valid[i] = 0;
        end
        m_err_ch = 0;
    endfunction

    function automatic void model_beat(input int ch, input int s);
        if (ch >= NUM_CH) begin
            m_err_ch = 1;
        end else begin
`ifdef ADC_AVG_EN
            if (!m_valid[ch]) m_acc[ch] = s * (1 << SH);
            else              m_acc[ch] = m_acc[ch] - m_acc[ch] / (1 << SH) + s;
`else
            m_acc[ch] = s;
`endif
            m_valid[ch] = 1;
        end
    endfunction

    function automatic logic [11:0] model_rd(input int ch);
        if (ch >= NUM_CH) return 12'h000;
`ifdef ADC_AVG_EN
        return 12'(m_acc[ch] / (1 << SH));
`else
        return 12'(m_acc[ch]);
`endif
    endfunction

    function automatic logic [NUM_CH-1:0] model_valid_vec();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic beat(input int ch, input int d, input bit sop, input bit eop);
        rsp_valid   = 1'b1;
        rsp_channel = 5'(ch);
        rsp_data    = 12'(d);
        rsp_sop     = sop;
        rsp_eop     = eop;
        model_beat(ch, d);
        @(negedge clk_clk);
        rsp_valid = 1'b0;
        rsp_sop   = 1'b0;
        rsp_eop   = 1'b0;
    endtask

    // Answers each poll read with status busy for the first 'ones' reads, then idle.
    task automatic run_poll(input int ones, output int reads, output bit finished);
        reads    = 0;
        finished = 0;
        for (int c = 0; c < 80; c++) begin
            if (!busy) begin
                finished = 1;
                break;
            end
            if (csr_read) begin
                reads++;
                csr_readdata = (reads <= ones) ? 32'h1 : 32'h0;
            end
            @(negedge clk_clk);
        end
        csr_readdata = 32'h0;
    endtask

    task automatic go_run(input bit sgl);
        start  = 1'b1;
        single = sgl;
        @(negedge clk_clk);
        start  = 1'b0;
        single = 1'b0;
        @(negedge clk_clk);
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        {start, stop, single, rsp_valid, rsp_sop, rsp_eop, err_clr} = '0;
        rsp_channel = '0; rsp_data = '0; rd_ch = '0; csr_readdata = '0;
        model_clear();
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        checks++;
        if ({busy, csr_write, csr_read, seq_done, err_timeout, err_ch} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, csr_write, csr_read, seq_done, err_timeout, err_ch});
        end
        checks++;
        if (sample_valid !== '0) begin
            errors++;
            $display("FAIL reset_valid: got %h expected 0", sample_valid);
        end
        checks++;
        if (rd_data !== 12'h000) begin
            errors++;
            $display("FAIL reset_rd: got %h expected 000", rd_data);
        end
    endtask

    task automatic test_bank_ch0();
        beat(0, 100, 0, 0);
        @(negedge clk_clk);
        checks++;
        if (rd_data !== model_rd(0)) begin
            errors++;
            $display("FAIL bank_ch0_first: got %0d expected %0d", rd_data, model_rd(0));
        end
        beat(0, 200, 0, 0);
        @(negedge clk_clk);
        checks++;
        if (rd_data !== model_rd(0)) begin
            errors++;
            $display("FAIL bank_ch0_second: got %0d expected %0d", rd_data, model_rd(0));
        end
    endtask

    task automatic test_start_cont();
        start = 1'b1;
        single = 1'b0;
        @(negedge clk_clk);
        start = 1'b0;
        checks++;
        if ({csr_write, csr_address, csr_writedata, busy} !== {1'b1, 1'b0, 32'h1, 1'b1}) begin
            errors++;
            $display("FAIL start_cont_wr: got wr=%b addr=%b wd=%h busy=%b expected 1 0 00000001 1",
                     csr_write, csr_address, csr_writedata, busy);
        end
        @(negedge clk_clk);
        checks++;
        if ({csr_write, busy} !== 2'b01) begin
            errors++;
            $display("FAIL start_cont_run: got wr=%b busy=%b expected 0 1", csr_write, busy);
        end
    endtask

    task automatic test_stop_poll();
        int  reads;
        bit  fin;
        stop = 1'b1;
        @(negedge clk_clk);
        stop = 1'b0;
        checks++;
        if ({csr_write, csr_writedata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL stop_wr: got wr=%b wd=%h expected 1 00000000", csr_write, csr_writedata);
        end
        run_poll(2, reads, fin);
        checks++;
        if (!fin || reads != 3 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL stop_poll: got reads=%0d idle=%0d err_to=%b expected 3 1 0",
                     reads, fin, err_timeout);
        end
    endtask

    task automatic test_single();
        start  = 1'b1;
        single = 1'b1;
        @(negedge clk_clk);
        start  = 1'b0;
        single = 1'b0;
        checks++;
        if ({csr_write, csr_writedata} !== {1'b1, 32'h3}) begin
            errors++;
            $display("FAIL single_wr: got wr=%b wd=%h expected 1 00000003", csr_write, csr_writedata);
        end
        @(negedge clk_clk);
        beat(3, 12'hABC, 1, 0);
        beat(4, 12'h123, 0, 1);
        checks++;
        if ({seq_done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL single_done: got done=%b busy=%b expected 1 0", seq_done, busy);
        end
        rd_ch = 5'd3;
        @(negedge clk_clk);
        checks++;
        if (seq_done !== 1'b0 || rd_data !== model_rd(3)) begin
            errors++;
            $display("FAIL single_rd3: got done=%b rd=%h expected 0 %h", seq_done, rd_data, model_rd(3));
        end
    endtask

    task automatic test_timeout();
        int  n;
        int  reads;
        bit  fin;
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        n = 0;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk_clk);
            if (err_timeout) begin
                n = c;
                break;
            end
        end
        // Counting starts the cycle after the start write: TO counted cycles, then one to register.
        checks++;
        if (n != TO + 1 || {csr_write, csr_writedata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL timeout: got at=%0d wr=%b wd=%h expected %0d 1 00000000",
                     n, csr_write, csr_writedata, TO + 1);
        end
        run_poll(0, reads, fin);
        checks++;
        if (!fin || reads != 1 || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_poll: got reads=%0d idle=%0d err_to=%b expected 1 1 1",
                     reads, fin, err_timeout);
        end
        err_clr = 1'b1;
        @(negedge clk_clk);
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clr: got %b expected 0", err_timeout);
        end
    endtask

    task automatic test_same_cycle();
        int  reads;
        bit  fin;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if ({csr_write, csr_writedata} !== {1'b1, 32'h1}) begin
            errors++;
            $display("FAIL idle_start_stop: got wr=%b wd=%h expected 1 00000001", csr_write, csr_writedata);
        end
        @(negedge clk_clk);
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        checks++;
        if ({csr_write, busy} !== 2'b01) begin
            errors++;
            $display("FAIL start_in_run: got wr=%b busy=%b expected 0 1", csr_write, busy);
        end
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if ({csr_write, csr_writedata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL run_start_stop: got wr=%b wd=%h expected 1 00000000", csr_write, csr_writedata);
        end
        run_poll(0, reads, fin);
        checks++;
        if (!fin || reads != 1) begin
            errors++;
            $display("FAIL same_cycle_poll: got reads=%0d idle=%0d expected 1 1", reads, fin);
        end
    endtask

    task automatic test_err_ch();
        logic [NUM_CH-1:0] sv_before;
        sv_before = sample_valid;
        beat(31, $urandom_range(0, 4095), 0, 0);
        checks++;
        if (err_ch !== 1'b1 || sample_valid !== sv_before) begin
            errors++;
            $display("FAIL err_ch_set: got err=%b valid=%h expected 1 %h", err_ch, sample_valid, sv_before);
        end
        err_clr = 1'b1;
        beat(NUM_CH + 2, 5, 0, 0);
        err_clr = 1'b0;
        checks++;
        if (err_ch !== 1'b1) begin
            errors++;
            $display("FAIL err_ch_clr_race: got %b expected 1", err_ch);
        end
        err_clr = 1'b1;
        @(negedge clk_clk);
        err_clr = 1'b0;
        m_err_ch = 0;
        checks++;
        if (err_ch !== 1'b0) begin
            errors++;
            $display("FAIL err_ch_clr: got %b expected 0", err_ch);
        end
    endtask

    task automatic test_random();
        int  reads;
        int  ones;
        bit  fin;
        go_run(1'b0);
        for (int b = 0; b < 80; b++) begin
            repeat ($urandom_range(0, 8)) @(negedge clk_clk);
            beat($urandom_range(0, NUM_CH + 3), $urandom_range(0, 4095), 0, 0);
        end
        checks++;
        if ({busy, err_timeout} !== 2'b10) begin
            errors++;
            $display("FAIL rand_run: got busy=%b err_to=%b expected 1 0", busy, err_timeout);
        end
        ones = $urandom_range(0, SPM - 1);
        stop = 1'b1;
        @(negedge clk_clk);
        stop = 1'b0;
        run_poll(ones, reads, fin);
        checks++;
        if (!fin || reads != ones + 1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rand_poll: got reads=%0d idle=%0d err_to=%b expected %0d 1 0",
                     reads, fin, err_timeout, ones + 1);
        end
        for (int ch = 0; ch < 32; ch++) begin
            rd_ch = 5'(ch);
            @(negedge clk_clk);
            checks++;
            if (rd_data !== model_rd(ch)) begin
                errors++;
                $display("FAIL rand_rd ch%0d: got %h expected %h", ch, rd_data, model_rd(ch));
            end
        end
        checks++;
        if (sample_valid !== model_valid_vec() || err_ch !== m_err_ch) begin
            errors++;
            $display("FAIL rand_flags: got valid=%h err_ch=%b expected %h %b",
                     sample_valid, err_ch, model_valid_vec(), m_err_ch);
        end
        err_clr = 1'b1;
        @(negedge clk_clk);
        err_clr = 1'b0;
        m_err_ch = 0;
    endtask

    task automatic test_poll_exhaust();
        int  reads;
        bit  fin;
        go_run(1'b0);
        stop = 1'b1;
        @(negedge clk_clk);
        stop = 1'b0;
        run_poll(1000, reads, fin);
        checks++;
        if (!fin || reads != SPM || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL poll_exhaust: got reads=%0d idle=%0d err_to=%b expected %0d 1 1",
                     reads, fin, err_timeout, SPM);
        end
        err_clr = 1'b1;
        @(negedge clk_clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int strobes;
        go_run(1'b0);
        beat(7, 12'h5A5, 0, 0);
        #2 reset_reset = 1'b1;
        #1;
        checks++;
        if ({busy, csr_write, csr_read, sample_valid} !== '0) begin
            errors++;
            $display("FAIL reset_async: got busy=%b wr=%b rd=%b valid=%h expected all 0",
                     busy, csr_write, csr_read, sample_valid);
        end
        model_clear();
        @(negedge clk_clk);
        reset_reset = 1'b0;
        strobes = 0;
        for (int c = 0; c < 6; c++) begin
            if (csr_write || csr_read || busy) strobes++;
            @(negedge clk_clk);
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d active cycles expected 0", strobes);
        end
    endtask

    initial begin
        test_reset();
        test_bank_ch0();
        test_start_cont();
        test_stop_poll();
        test_single();
        test_timeout();
        test_same_cycle();
        test_err_ch();
        test_random();
        test_poll_exhaust();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
